// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
// FSM state encoding and counter-width helper.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Bit-counter width for a WIDTH-bit serial operation (at least 1 bit).
  function automatic int cnt_w(input int w);
    int r;
    r = $clog2(w);
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_full_adder_cell.sv
// Single combinational full-adder cell.
// Shared by the serial add/subtract datapath.
module serial_full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_minuend_restore.sv
// Bit-serial minuend rebuild A = D + B, LSB first, one bit per clock.
// Optional SERIAL_SUB_MODE_EN adds op_sub for D - B with borrow out.
module serial_minuend_restore
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  input  logic [WIDTH-1:0] b_in,
`ifdef SERIAL_SUB_MODE_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic             carry_out
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  state_e           state_nx;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_nx;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             sub_q;
  logic             sub_in;
  logic             fa_s;
  logic             fa_co;
  logic             last;
  logic [WIDTH-1:0] a_q;
  logic             co_q;

`ifdef SERIAL_SUB_MODE_EN
  assign sub_in = op_sub;
`else
  assign sub_in = 1'b0;
`endif

  serial_full_adder_cell u_fa (
    .a    (d_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_co)
  );

  assign last   = (cnt == LAST);
  assign res_nx = {fa_s, res[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == ST_IDLE):  if (in_valid)  state_nx = ST_SHIFT;
      (state == ST_SHIFT): if (last)      state_nx = ST_DONE;
      (state == ST_DONE):  if (out_ready) state_nx = ST_IDLE;
      default:             state_nx = ST_IDLE;
    endcase
  end

  // Serial datapath: load on accept, one bit per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      sub_q <= 1'b0;
      a_q   <= '0;
      co_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (in_valid) begin
            d_sh  <= d_in;
            b_sh  <= b_in ^ {WIDTH{sub_in}};
            carry <= sub_in;
            sub_q <= sub_in;
            cnt   <= '0;
          end
        end
        (state == ST_SHIFT): begin
          carry <= fa_co;
          res   <= res_nx;
          d_sh  <= d_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          if (last) begin
            a_q  <= res_nx;
            co_q <= fa_co ^ sub_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE) && !rst;
  assign out_valid = (state == ST_DONE);
  assign a_out     = a_q;
  assign carry_out = co_q;

endmodule

// File: tb/tb_serial_minuend_restore.sv
// Randomized bench for serial_minuend_restore, WIDTH=4.
// Expected results come from plain integer add/subtract.
module tb_serial_minuend_restore;

  localparam int W = 4;
  localparam int LIM = 4 * W + 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] d_in;
  logic [W-1:0] b_in;
`ifdef SERIAL_SUB_MODE_EN
  logic         op_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] a_out;
  logic         carry_out;

  int vecs = 0;
  int errs = 0;

  serial_minuend_restore #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d_in      (d_in),
    .b_in      (b_in),
`ifdef SERIAL_SUB_MODE_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: (D + B) mod 2^W with carry, or D - B with borrow.
  task automatic model(input int d, input int b, input bit sub,
                       output int a, output bit c);
    int r;
    if (sub) begin
      r = d - b;
      a = r & ((1 << W) - 1);
      c = (d < b);
    end else begin
      r = d + b;
      a = r & ((1 << W) - 1);
      c = (r >= (1 << W));
    end
  endtask

  // One full transaction; optional DONE hold and a stray pair mid-SHIFT.
  task automatic run(input int d, input int b, input bit sub,
                     input int hold, input bit inject);
    int  ea;
    bit  ec;
    int  n;
    model(d, b, sub, ea, ec);
    n = 0;
    while (!in_ready && n < LIM) begin
      tick();
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    d_in     = W'(d);
    b_in     = W'(b);
`ifdef SERIAL_SUB_MODE_EN
    op_sub   = sub;
`endif
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < LIM) begin
      if (inject && n == 1) begin
        chk("in_ready_shift", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        d_in     = 4'hA;
        b_in     = 4'h6;
      end
      tick();
      in_valid = 1'b0;
      n++;
    end
    chk("latency", n, W);
    chk("a_out", 32'(a_out), ea);
    chk("carry_out", 32'(carry_out), 32'(ec));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_a", 32'(a_out), ea);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drop_valid", 32'(out_valid), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd1);
    chk("keep_a", 32'(a_out), ea);
  endtask

  initial begin
    int d;
    int b;
    bit s;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d_in      = '0;
    b_in      = '0;
`ifdef SERIAL_SUB_MODE_EN
    op_sub    = 1'b0;
`endif
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_carry", 32'(carry_out), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    run(4'h5, 4'h3, 1'b0, 0, 1'b0);
    run(4'hF, 4'h1, 1'b0, 0, 1'b0);
    run(4'h9, 4'h8, 1'b0, 5, 1'b0);
    run(4'h6, 4'h7, 1'b0, 0, 1'b1);
    run(4'h0, 4'h0, 1'b0, 1, 1'b0);
    run(4'hF, 4'hF, 1'b0, 0, 1'b0);

    // Abort mid-operation with reset on the 2nd SHIFT cycle.
    d_in     = 4'h7;
    b_in     = 4'h7;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_a", 32'(a_out), 32'd0);
    chk("abort_carry", 32'(carry_out), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    run(2, 2, 1'b0, 0, 1'b0);

`ifdef SERIAL_SUB_MODE_EN
    run(4'h3, 4'h5, 1'b1, 0, 1'b0);
    run(4'h7, 4'h2, 1'b1, 2, 1'b0);
`endif

    for (int i = 0; i < 40; i++) begin
      d = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
`ifdef SERIAL_SUB_MODE_EN
      s = bit'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      run(d, b, s, int'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
